matrix_loader: RTL and testbench

Front-end stage for the determinant engine. It accepts the 8x8 signed matrix one element per transfer over a valid/ready stream and holds it as a flat bus wired to the engine's `input_arr`. It then drives the engine's Start/Ack handshake, captures the returned `det`, and holds that result until the consumer acknowledges it.

---
 rtl/matrix_loader.sv | 141 ++++++++++++++
 tb/tb_matrix_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Streams an NxN signed matrix into a flat register bus, runs the determinant
// engine's Start/Ack handshake and holds the returned determinant until acknowledged.
module matrix_loader #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Begin,
  input  logic             Abort,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [N*N*W-1:0] mat_flat,
  output logic             eng_start,
  output logic             eng_ack,
  input  logic             eng_done,
  input  logic [W-1:0]     eng_det,
  output logic [W-1:0]     det_out,
  output logic             det_valid,
  input  logic             det_ack,
  output logic [6:0]       count,
  output logic             q_I,
  output logic             q_Fill,
  output logic             q_Go,
  output logic             q_Wait,
  output logic             q_Ack,
  output logic             q_Hold
);

  localparam int NN = N * N;

  typedef enum logic [5:0] {
    S_I    = 6'b000001,
    S_FILL = 6'b000010,
    S_GO   = 6'b000100,
    S_WAIT = 6'b001000,
    S_ACK  = 6'b010000,
    S_HOLD = 6'b100000
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   count_clear;
  logic   det_capture;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_I;
    end else begin
      state <= state_next;
    end
  end

  // Abort wins over a same-cycle transfer, so accept is masked by it.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    count_clear = 1'b0;
    det_capture = 1'b0;
    case (state)
      S_I: begin
        if (Begin) begin
          state_next  = S_FILL;
          count_clear = 1'b1;
        end
      end
      S_FILL: begin
        if (Abort) begin
          state_next  = S_I;
          count_clear = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (count == 7'(NN - 1)) begin
            state_next = S_GO;
          end
        end
      end
      S_GO:   state_next = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          state_next  = S_ACK;
          det_capture = 1'b1;
        end
      end
      S_ACK:  state_next = S_HOLD;
      S_HOLD: begin
        if (det_ack) begin
          state_next = S_I;
        end
      end
      default: state_next = S_I;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= 7'd0;
    end else if (count_clear) begin
      count <= 7'd0;
    end else if (accept) begin
      count <= count + 7'd1;
    end
  end

  // Row-major storage: element index equals the running count.
  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_elem
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          mat_flat[gi*W +: W] <= '0;
        end else if (accept && (count == 7'(gi))) begin
          mat_flat[gi*W +: W] <= in_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      det_out <= '0;
    end else if (det_capture) begin
      det_out <= eng_det;
    end
  end

  assign q_I    = state[0];
  assign q_Fill = state[1];
  assign q_Go   = state[2];
  assign q_Wait = state[3];
  assign q_Ack  = state[4];
  assign q_Hold = state[5];

  assign in_ready  = q_Fill;
  assign eng_start = q_Go;
  assign eng_ack   = q_Ack;
  assign det_valid = q_Hold;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: inputs change just after the falling edge,
// outputs are sampled at the falling edge, and the engine is modelled inline.
module tb_matrix_loader;

  localparam int N = 8;
  localparam int W = 32;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Begin = 1'b0;
  logic             Abort = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready;
  logic [N*N*W-1:0] mat_flat;
  logic             eng_start;
  logic             eng_ack;
  logic             eng_done = 1'b0;
  logic [W-1:0]     eng_det = '0;
  logic [W-1:0]     det_out;
  logic             det_valid;
  logic             det_ack = 1'b0;
  logic [6:0]       count;
  logic             q_I, q_Fill, q_Go, q_Wait, q_Ack, q_Hold;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_mat [N*N];

  matrix_loader #(.N(N), .W(W)) dut (
    .Clk(Clk), .Reset(Reset), .Begin(Begin), .Abort(Abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mat_flat(mat_flat), .eng_start(eng_start), .eng_ack(eng_ack),
    .eng_done(eng_done), .eng_det(eng_det), .det_out(det_out),
    .det_valid(det_valid), .det_ack(det_ack), .count(count),
    .q_I(q_I), .q_Fill(q_Fill), .q_Go(q_Go), .q_Wait(q_Wait),
    .q_Ack(q_Ack), .q_Hold(q_Hold)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(negedge Clk);
  endtask

  function automatic logic [W-1:0] elem(input int idx);
    return mat_flat[idx*W +: W];
  endfunction

  // Pulses Begin then streams exp_mat; optional gap every third cycle.
  // Returns with the block in GO; early counts eng_start seen before the last accept.
  task automatic do_load(input bit gaps, output int early);
    int v;
    int c;
    early = 0;
    Begin = 1'b1;
    tick();
    Begin = 1'b0;
    v = 0;
    c = 0;
    while (v < N*N) begin
      if (gaps && (c % 3 == 2)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = exp_mat[v];
        v++;
      end
      tick();
      if (v < N*N && eng_start) early++;
      c++;
    end
    in_valid = 1'b0;
  endtask

  // From GO: wait in WAIT for delay cycles, return det, end in HOLD.
  task automatic run_engine(input logic [W-1:0] det, input int delay);
    tick();
    repeat (delay) tick();
    eng_done = 1'b1;
    eng_det  = det;
    tick();
    eng_done = 1'b0;
    tick();
  endtask

  task automatic release_hold;
    det_ack = 1'b1;
    tick();
    det_ack = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (3) tick();
    checks++; if (q_I !== 1'b1) begin errors++; $display("FAIL reset_state: q_I=%b expected 1", q_I); end
    checks++; if (count !== 7'd0 || mat_flat !== '0 || det_out !== '0) begin
      errors++; $display("FAIL reset_values: count=%0d mat_nonzero=%b det_out=%h expected 0", count, |mat_flat, det_out);
    end
    checks++; if ({in_ready, eng_start, eng_ack, det_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {in_ready, eng_start, eng_ack, det_valid});
    end
    Reset = 1'b1;
    tick();
    Begin = 1'b1;
    tick();
    Begin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd100 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 7'd20 || elem(19) !== 32'd119) begin
      errors++; $display("FAIL fill_20: count=%0d elem19=%0d expected 20/119", count, elem(19));
    end
    #2 Reset = 1'b0;
    #1;
    checks++; if (q_I !== 1'b1 || count !== 7'd0 || mat_flat !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset: q_I=%b count=%0d mat_nonzero=%b in_ready=%b expected 1/0/0/0", q_I, count, |mat_flat, in_ready);
    end
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_identity;
    int early;
    int acks;
    for (int i = 0; i < N*N; i++) exp_mat[i] = (i % 9 == 0) ? 32'd1 : 32'd0;
    do_load(1'b0, early);
    checks++; if (early !== 0) begin errors++; $display("FAIL id_early_start: saw %0d expected 0", early); end
    checks++; if (eng_start !== 1'b1 || q_Go !== 1'b1) begin
      errors++; $display("FAIL id_start: eng_start=%b q_Go=%b expected 1/1", eng_start, q_Go);
    end
    checks++; if (mat_flat[31:0] !== 32'd1 || mat_flat[63:32] !== 32'd0 || elem(63) !== 32'd1) begin
      errors++; $display("FAIL id_matrix: e0=%h e1=%h e63=%h expected 1/0/1", mat_flat[31:0], mat_flat[63:32], elem(63));
    end
    tick();
    checks++; if (eng_start !== 1'b0 || q_Wait !== 1'b1) begin
      errors++; $display("FAIL id_start_pulse: eng_start=%b q_Wait=%b expected 0/1", eng_start, q_Wait);
    end
    repeat (2) tick();
    eng_done = 1'b1;
    eng_det  = 32'd1;
    tick();
    acks = eng_ack ? 1 : 0;
    eng_done = 1'b0;
    checks++; if (det_out !== 32'd1 || det_valid !== 1'b0) begin
      errors++; $display("FAIL id_capture: det_out=%h det_valid=%b expected 1/0", det_out, det_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (eng_ack) acks++;
    end
    checks++; if (det_valid !== 1'b1) begin errors++; $display("FAIL id_det_valid: got %b expected 1", det_valid); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL id_ack_pulses: got %0d expected 1", acks); end
    release_hold();
    checks++; if (det_valid !== 1'b0 || q_I !== 1'b1 || det_out !== 32'd1) begin
      errors++; $display("FAIL id_release: det_valid=%b q_I=%b det_out=%h expected 0/1/1", det_valid, q_I, det_out);
    end
  endtask

  task automatic test_backpressure;
    int early;
    for (int i = 0; i < N*N; i++) exp_mat[i] = 32'(i);
    do_load(1'b1, early);
    checks++; if (early !== 0 || eng_start !== 1'b1) begin
      errors++; $display("FAIL bp_start: early=%0d eng_start=%b expected 0/1", early, eng_start);
    end
    checks++; if (elem(63) !== 32'd63 || elem(2*N+5) !== 32'd21) begin
      errors++; $display("FAIL bp_elements: e77=%0d e25=%0d expected 63/21", elem(63), elem(2*N+5));
    end
    run_engine(32'd5, 1);
    checks++; if (det_out !== 32'd5 || det_valid !== 1'b1) begin
      errors++; $display("FAIL bp_det: det_out=%h det_valid=%b expected 5/1", det_out, det_valid);
    end
    release_hold();
  endtask

  task automatic test_abort;
    Begin = 1'b1;
    tick();
    Begin = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd500 + 32'(i);
      tick();
    end
    in_valid = 1'b1;
    in_data  = 32'd999;
    Abort    = 1'b1;
    tick();
    Abort    = 1'b0;
    in_valid = 1'b0;
    checks++; if (q_I !== 1'b1 || count !== 7'd0) begin
      errors++; $display("FAIL abort_state: q_I=%b count=%0d expected 1/0", q_I, count);
    end
    checks++; if (elem(N+1) !== 32'd9 || elem(0) !== 32'd500) begin
      errors++; $display("FAIL abort_elements: e11=%0d e00=%0d expected 9/500", elem(N+1), elem(0));
    end
    in_valid = 1'b1;
    in_data  = 32'd777;
    repeat (3) tick();
    in_valid = 1'b0;
    checks++; if (elem(0) !== 32'd500 || count !== 7'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: e00=%0d count=%0d in_ready=%b expected 500/0/0", elem(0), count, in_ready);
    end
  endtask

  task automatic test_negative;
    int early;
    for (int i = 0; i < N*N; i++) exp_mat[i] = 32'(3 * i);
    do_load(1'b0, early);
    tick();
    for (int i = 0; i < 500; i++) begin
      Begin = (i == 100);
      tick();
    end
    Begin = 1'b0;
    checks++; if (q_Wait !== 1'b1 || count !== 7'd64) begin
      errors++; $display("FAIL neg_wait_hold: q_Wait=%b count=%0d expected 1/64", q_Wait, count);
    end
    eng_done = 1'b1;
    eng_det  = 32'hFFFFFF38;
    tick();
    eng_done = 1'b0;
    tick();
    checks++; if ($signed(det_out) !== -32'sd200 || det_valid !== 1'b1) begin
      errors++; $display("FAIL neg_det: det_out=%0d det_valid=%b expected -200/1", $signed(det_out), det_valid);
    end
    Begin = 1'b1;
    tick();
    Begin = 1'b0;
    checks++; if (q_Hold !== 1'b1 || elem(63) !== 32'd189) begin
      errors++; $display("FAIL neg_begin_in_hold: q_Hold=%b e77=%0d expected 1/189", q_Hold, elem(63));
    end
    release_hold();
    checks++; if (q_I !== 1'b1 || det_out !== 32'hFFFFFF38) begin
      errors++; $display("FAIL neg_release: q_I=%b det_out=%h expected 1/ffffff38", q_I, det_out);
    end
  endtask

  task automatic test_back_to_back;
    int early;
    int bad;
    for (int i = 0; i < N*N; i++) exp_mat[i] = 32'(i + 1);
    do_load(1'b0, early);
    run_engine(32'd7, 0);
    release_hold();
    checks++; if (det_out !== 32'd7 || elem(10) !== 32'd11) begin
      errors++; $display("FAIL b2b_first: det_out=%0d e12=%0d expected 7/11", det_out, elem(10));
    end
    for (int i = 0; i < N*N; i++) exp_mat[i] = 32'd2;
    do_load(1'b0, early);
    bad = 0;
    for (int i = 0; i < N*N; i++) if (elem(i) !== 32'd2) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_overwrite: %0d elements differ from 2", bad); end
    tick();
    tick();
    checks++; if (det_out !== 32'd7 || q_Wait !== 1'b1) begin
      errors++; $display("FAIL b2b_det_before: det_out=%0d q_Wait=%b expected 7/1", det_out, q_Wait);
    end
    eng_done = 1'b1;
    eng_det  = 32'd0;
    tick();
    eng_done = 1'b0;
    checks++; if (det_out !== 32'd0 || eng_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_det_at_ack: det_out=%0d eng_ack=%b expected 0/1", det_out, eng_ack);
    end
    tick();
    release_hold();
    checks++; if (q_I !== 1'b1) begin errors++; $display("FAIL b2b_end: q_I=%b expected 1", q_I); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_backpressure();
    test_abort();
    test_negative();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
